// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared types for the core-side memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arbiter FSM states, transaction owner tag and the default
// byte-enable width of the core memory interface.
package core_mem_pkg;

  // Default core data width and its byte-enable width.
  localparam int CORE_DATA_W = 32;
  localparam int BE_W        = CORE_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store.
// Latency: grant at T, mem_req from T+1; read data at T+3 best case, store ack at T+2.
// Backpressure: mem_req and its attributes hold until mem_ready; no grants leave IDLE.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt         fetch request, accepted by a one-cycle grant
//   if_rvalid/if_rdata               fetch data return pulse
//   d_req/d_we/d_be/d_addr/d_wdata   load/store request
//   d_gnt, d_rvalid/d_rdata          data grant, load data or store-done pulse
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata, mem_ready   memory request side
//   mem_rvalid/mem_rdata             memory read return
module mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int          BeW       = DATA_W / 8;
  localparam logic [3:0]  StarveMax = STARVE_MAX[3:0];

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  arb_owner_t           r_owner;
  logic [3:0]           r_starve_cnt;

  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [BeW-1:0]       r_mem_be;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;

  logic                 r_if_rvalid;
  logic [DATA_W-1:0]    r_if_rdata;
  logic                 r_d_rvalid;
  logic [DATA_W-1:0]    r_d_rdata;

  logic                 w_idle;
  logic                 w_starved;
  logic                 w_if_win;
  logic                 w_d_win;

  // Grants are only issued from IDLE; holding them off during reset keeps
  // a requester from believing it was accepted by an FSM that is clearing.
  assign w_idle    = (r_state == IDLE) && !reset;
  assign w_starved = (r_starve_cnt == StarveMax);

  // Data wins a tie unless fetch has been passed over STARVE_MAX times.
  assign w_if_win = w_idle && if_req && (!d_req || w_starved);
  assign w_d_win  = w_idle && d_req && !w_if_win;

  assign if_gnt = w_if_win;
  assign d_gnt  = w_d_win;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_if_win || w_d_win) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        // Fetches always latch we=0, so r_mem_we alone marks a store.
        if (mem_ready) begin
          w_state_nxt = r_mem_we ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch toward memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_if_win) begin
        r_owner     <= OWN_IF;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_be    <= '1;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
      end else if (w_d_win) begin
        r_owner     <= OWN_D;
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_be    <= d_be;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else if (r_state == REQ && mem_ready) begin
        // Attributes stay as they were; only the request strobe drops.
        r_mem_req <= 1'b0;
      end
    end
  end

  // Response routing back to the owning requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (r_state == REQ && mem_ready && r_mem_we) begin
        // Store completes on acceptance; memory returns nothing for it.
        r_d_rvalid <= 1'b1;
        r_d_rdata  <= '0;
      end else if (r_state == WAIT && mem_rvalid) begin
        if (r_owner == OWN_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem_rdata;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= mem_rdata;
        end
      end
    end
  end

  // Starvation counter: counts data grants taken while a fetch was waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_if_win || !if_req) begin
        r_starve_cnt <= '0;
      end else if (w_d_win && (r_starve_cnt != StarveMax)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with hand-computed expectations.
// Latency: inputs driven 2 time units after each rising edge, outputs checked 1 unit later.
// Backpressure: memory handshake (mem_ready/mem_rvalid) driven directly by the sequence.
module tb_mem_arbiter;
  import core_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_if;

    reset      = 1'b1;
    if_req     = 1'b0;
    if_addr    = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_be       = '0;
    d_addr     = '0;
    d_wdata    = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state.
    repeat (3) cyc();
    #1;
    chk("rst_mem_req",  mem_req,  0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be",   mem_be,   0);
    chk("rst_if_rv",    if_rvalid, 0);
    chk("rst_d_rv",     d_rvalid, 0);
    chk("rst_starve",   dut.r_starve_cnt, 0);

    // Fetch read.
    cyc(); reset = 1'b0;
    cyc(); if_req = 1'b1; if_addr = 32'h100; #1;
    chk("f_if_gnt", if_gnt, 1);
    chk("f_d_gnt",  d_gnt,  0);
    cyc(); if_req = 1'b0; mem_ready = 1'b1; #1;
    chk("f_mem_req",  mem_req,  1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we",   mem_we,   0);
    chk("f_mem_be",   mem_be,   4'hf);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("f_rv_early", if_rvalid, 0);
    chk("f_req_drop", mem_req,   0);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("f_if_rv",    if_rvalid, 1);
    chk("f_if_rdata", if_rdata,  32'hDEADBEEF);
    chk("f_d_rv",     d_rvalid,  0);
    cyc(); #1;
    chk("f_rv_pulse", if_rvalid, 0);

    // Tie: data wins, fetch follows in the IDLE cycle of d_rvalid.
    cyc(); if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; #1;
    chk("t_d_gnt",  d_gnt,  1);
    chk("t_if_gnt", if_gnt, 0);
    cyc(); d_req = 1'b0; mem_ready = 1'b1; #1;
    chk("t_mem_addr", mem_addr, 32'h2000);
    chk("t_no_gnt",   if_gnt,   0);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001; #1;
    chk("t_wait_gnt", if_gnt, 0);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("t_d_rv",     d_rvalid, 1);
    chk("t_d_rdata",  d_rdata,  32'hCAFE0001);
    chk("t_if_gnt2",  if_gnt,   1);
    cyc(); if_req = 1'b0; mem_ready = 1'b1; #1;
    chk("t_if_addr",  mem_addr, 32'h300);
    chk("t_if_we",    mem_we,   0);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111; #1;
    cyc(); mem_rvalid = 1'b0; #1;
    chk("t_if_rv",    if_rvalid, 1);
    chk("t_if_rdata", if_rdata,  32'h11111111);
    chk("t_d_rv0",    d_rvalid,  0);

    // Starvation: both held; expect D,D,D,D,IF,D.
    cyc(); if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2100; #1;
    for (int i = 0; i < 6; i++) begin
      exp_if = (i == 4);
      chk($sformatf("s%0d_if_gnt", i), if_gnt, exp_if);
      chk($sformatf("s%0d_d_gnt", i),  d_gnt,  !exp_if);
      chk($sformatf("s%0d_cnt", i),    dut.r_starve_cnt, (i <= 4) ? i : 0);
      cyc(); mem_ready = 1'b1; #1;
      chk($sformatf("s%0d_hold", i), if_gnt | d_gnt, 0);
      chk($sformatf("s%0d_addr", i), mem_addr, exp_if ? 32'h400 : 32'h2100);
      cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0 + i; #1;
      cyc(); mem_rvalid = 1'b0;
      if (i == 5) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      #1;
      chk($sformatf("s%0d_if_rv", i), if_rvalid, exp_if);
      chk($sformatf("s%0d_d_rv", i),  d_rvalid,  !exp_if);
      chk($sformatf("s%0d_rdata", i), exp_if ? if_rdata : d_rdata, 32'hA0 + i);
    end

    // Store, then a fetch granted in the d_rvalid cycle.
    cyc(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2004; d_wdata = 32'h1234; #1;
    chk("w_d_gnt", d_gnt, 1);
    cyc(); d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1; #1;
    chk("w_mem_req",   mem_req,   1);
    chk("w_mem_we",    mem_we,    1);
    chk("w_mem_be",    mem_be,    4'b0011);
    chk("w_mem_wdata", mem_wdata, 32'h1234);
    chk("w_mem_addr",  mem_addr,  32'h2004);
    cyc(); mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h500; #1;
    chk("w_d_rv",    d_rvalid, 1);
    chk("w_d_rdata", d_rdata,  0);
    chk("w_if_gnt",  if_gnt,   1);

    // Backpressure: mem_ready low for 3 cycles with another fetch pending.
    cyc(); if_addr = 32'h600; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b%0d_req", k),  mem_req,  1);
      chk($sformatf("b%0d_addr", k), mem_addr, 32'h500);
      chk($sformatf("b%0d_be", k),   mem_be,   4'hf);
      chk($sformatf("b%0d_gnt", k),  if_gnt,   0);
      if (k < 2) begin
        cyc(); #1;
      end
    end
    cyc(); mem_ready = 1'b1; #1;
    chk("b_ready_addr", mem_addr, 32'h500);
    chk("b_ready_gnt",  if_gnt,   0);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
    chk("b_wait_gnt", if_gnt, 0);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("b_if_rv",    if_rvalid, 1);
    chk("b_if_rdata", if_rdata,  32'h55);
    chk("b_if_gnt",   if_gnt,    1);

    // Reset while in WAIT, then a late mem_rvalid.
    cyc(); if_req = 1'b0; mem_ready = 1'b1; #1;
    chk("r_mem_addr", mem_addr, 32'h600);
    cyc(); mem_ready = 1'b0; reset = 1'b1; #1;
    chk("r_in_wait", dut.r_state, WAIT);
    cyc(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; #1;
    chk("r_mem_req",   mem_req,   0);
    chk("r_mem_addr0", mem_addr,  0);
    chk("r_mem_we",    mem_we,    0);
    chk("r_mem_be",    mem_be,    0);
    chk("r_mem_wdata", mem_wdata, 0);
    chk("r_if_rdata",  if_rdata,  0);
    chk("r_d_rdata",   d_rdata,   0);
    chk("r_if_rv",     if_rvalid, 0);
    chk("r_d_rv",      d_rvalid,  0);
    chk("r_state",     dut.r_state, IDLE);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("r_late_if_rv", if_rvalid, 0);
    chk("r_late_d_rv",  d_rvalid,  0);
    chk("r_late_rdata", if_rdata,  0);

    // Clean transaction after reset.
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008; #1;
    chk("p_d_gnt", d_gnt, 1);
    cyc(); d_req = 1'b0; mem_ready = 1'b1; #1;
    chk("p_mem_addr", mem_addr, 32'h2008);
    cyc(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
    cyc(); mem_rvalid = 1'b0; #1;
    chk("p_d_rv",    d_rvalid,  1);
    chk("p_d_rdata", d_rdata,   32'h12345678);
    chk("p_if_rv",   if_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
